// File: rtl/morse_keyer_sequencer.sv
// Character-level Morse keyer: looks up ASCII characters in an ITU code ROM,
// sequences mark/space/gap timing in units and gates a free-running tone onto oSOUND.
module morse_keyer_sequencer #(
    parameter int UNIT_CYCLES = 3000000,
    parameter int TONE_HALF   = 25000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iVALID,
    input  logic [7:0] iCHAR,
    output logic       oREADY,
    output logic       oBUSY,
    output logic       oERR,
    output logic       oKEY,
    output logic       oSOUND
);

    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        SPACE,
        LGAP,
        WGAP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [UW-1:0] unit_cnt;
    logic [UW-1:0] unit_cnt_next;
    logic [1:0]    units_left;
    logic [1:0]    units_left_next;
    logic [4:0]    shreg;
    logic [4:0]    shreg_next;
    logic [2:0]    sym_left;
    logic [2:0]    sym_left_next;
    logic [7:0]    char_q;
    logic [7:0]    char_next;
    logic          err_q;
    logic          err_next;
    logic          key_q;
    logic          key_next;
    logic          sound_q;
    logic [TW-1:0] tone_cnt;
    logic          phase;

    logic [7:0]    rom_entry;
    logic [2:0]    rom_len;
    logic [4:0]    rom_pat;
    logic          unit_done;
    logic          interval_done;

    // ROM entry: {length, pattern left-aligned so the current symbol is bit 4, 1 = dash}.
    // A zero length marks an unsupported character.
    function automatic logic [7:0] rom_lookup(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        case (u)
            8'h41: rom_lookup = {3'd2, 5'b01000};
            8'h42: rom_lookup = {3'd4, 5'b10000};
            8'h43: rom_lookup = {3'd4, 5'b10100};
            8'h44: rom_lookup = {3'd3, 5'b10000};
            8'h45: rom_lookup = {3'd1, 5'b00000};
            8'h46: rom_lookup = {3'd4, 5'b00100};
            8'h47: rom_lookup = {3'd3, 5'b11000};
            8'h48: rom_lookup = {3'd4, 5'b00000};
            8'h49: rom_lookup = {3'd2, 5'b00000};
            8'h4A: rom_lookup = {3'd4, 5'b01110};
            8'h4B: rom_lookup = {3'd3, 5'b10100};
            8'h4C: rom_lookup = {3'd4, 5'b01000};
            8'h4D: rom_lookup = {3'd2, 5'b11000};
            8'h4E: rom_lookup = {3'd2, 5'b10000};
            8'h4F: rom_lookup = {3'd3, 5'b11100};
            8'h50: rom_lookup = {3'd4, 5'b01100};
            8'h51: rom_lookup = {3'd4, 5'b11010};
            8'h52: rom_lookup = {3'd3, 5'b01000};
            8'h53: rom_lookup = {3'd3, 5'b00000};
            8'h54: rom_lookup = {3'd1, 5'b10000};
            8'h55: rom_lookup = {3'd3, 5'b00100};
            8'h56: rom_lookup = {3'd4, 5'b00010};
            8'h57: rom_lookup = {3'd3, 5'b01100};
            8'h58: rom_lookup = {3'd4, 5'b10010};
            8'h59: rom_lookup = {3'd4, 5'b10110};
            8'h5A: rom_lookup = {3'd4, 5'b11000};
            8'h30: rom_lookup = {3'd5, 5'b11111};
            8'h31: rom_lookup = {3'd5, 5'b01111};
            8'h32: rom_lookup = {3'd5, 5'b00111};
            8'h33: rom_lookup = {3'd5, 5'b00011};
            8'h34: rom_lookup = {3'd5, 5'b00001};
            8'h35: rom_lookup = {3'd5, 5'b00000};
            8'h36: rom_lookup = {3'd5, 5'b10000};
            8'h37: rom_lookup = {3'd5, 5'b11000};
            8'h38: rom_lookup = {3'd5, 5'b11100};
            8'h39: rom_lookup = {3'd5, 5'b11110};
            default: rom_lookup = 8'h00;
        endcase
    endfunction

    assign rom_entry     = rom_lookup(char_q);
    assign rom_len       = rom_entry[7:5];
    assign rom_pat       = rom_entry[4:0];
    assign unit_done     = (unit_cnt == UNIT_LAST);
    assign interval_done = unit_done && (units_left == 2'd0);

    // units_left holds the number of whole units still to run after the current one,
    // so an interval ends on the last cycle of its final unit.
    always_comb begin
        state_next      = state;
        unit_cnt_next   = unit_cnt;
        units_left_next = units_left;
        shreg_next      = shreg;
        sym_left_next   = sym_left;
        char_next       = char_q;
        err_next        = 1'b0;

        if (state == MARK || state == SPACE || state == LGAP || state == WGAP) begin
            unit_cnt_next = unit_done ? '0 : unit_cnt + 1'b1;
            if (unit_done && units_left != 2'd0) begin
                units_left_next = units_left - 2'd1;
            end
        end

        case (state)
            IDLE: begin
                if (iVALID) begin
                    char_next  = iCHAR;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                unit_cnt_next = '0;
                if (char_q == 8'h20) begin
                    units_left_next = 2'd3;
                    state_next      = WGAP;
                end else if (rom_len != 3'd0) begin
                    shreg_next      = rom_pat;
                    sym_left_next   = rom_len;
                    units_left_next = rom_pat[4] ? 2'd2 : 2'd0;
                    state_next      = MARK;
                end else begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            MARK: begin
                if (interval_done) begin
                    if (sym_left > 3'd1) begin
                        shreg_next      = {shreg[3:0], 1'b0};
                        sym_left_next   = sym_left - 3'd1;
                        units_left_next = 2'd0;
                        state_next      = SPACE;
                    end else begin
                        units_left_next = 2'd2;
                        state_next      = LGAP;
                    end
                end
            end
            SPACE: begin
                if (interval_done) begin
                    units_left_next = shreg[4] ? 2'd2 : 2'd0;
                    state_next      = MARK;
                end
            end
            LGAP, WGAP: begin
                if (interval_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign key_next = (state_next == MARK);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            unit_cnt   <= '0;
            units_left <= 2'd0;
            shreg      <= 5'd0;
            sym_left   <= 3'd0;
            char_q     <= 8'd0;
            err_q      <= 1'b0;
            key_q      <= 1'b0;
            sound_q    <= 1'b0;
            tone_cnt   <= '0;
            phase      <= 1'b0;
        end else begin
            state      <= state_next;
            unit_cnt   <= unit_cnt_next;
            units_left <= units_left_next;
            shreg      <= shreg_next;
            sym_left   <= sym_left_next;
            char_q     <= char_next;
            err_q      <= err_next;
            key_q      <= key_next;
            sound_q    <= key_next & phase;
            if (tone_cnt == TONE_LAST) begin
                tone_cnt <= '0;
                phase    <= ~phase;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end
        end
    end

    assign oREADY = (state == IDLE);
    assign oBUSY  = (state != IDLE);
    assign oERR   = err_q;
    assign oKEY   = key_q;
    assign oSOUND = sound_q;

endmodule

// File: tb/tb_morse_keyer_sequencer.sv
// Bench for morse_keyer_sequencer: vector table, hand-written corner sequences and
// random characters, all checked against a timeline built from Morse timing rules.
module tb_morse_keyer_sequencer;

    localparam int UNIT = 4;
    localparam int TONE = 2;

    logic       iCLK   = 1'b0;
    logic       iRST   = 1'b1;
    logic       iVALID = 1'b0;
    logic [7:0] iCHAR  = 8'h00;
    logic       oREADY;
    logic       oBUSY;
    logic       oERR;
    logic       oKEY;
    logic       oSOUND;

    int checks     = 0;
    int errors     = 0;
    int edge_count = 0;

    typedef struct {
        logic [7:0] ch;
        string      code;
        bit         hold;
    } vec_t;

    vec_t vecs[$];

    string letter_code [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                                "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                                "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                                "-.--", "--.."};
    string digit_code [10] = '{"-----", ".----", "..---", "...--", "....-",
                               ".....", "-....", "--...", "---..", "----."};

    morse_keyer_sequencer #(
        .UNIT_CYCLES(UNIT),
        .TONE_HALF  (TONE)
    ) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iVALID(iVALID),
        .iCHAR (iCHAR),
        .oREADY(oREADY),
        .oBUSY (oBUSY),
        .oERR  (oERR),
        .oKEY  (oKEY),
        .oSOUND(oSOUND)
    );

    always #5 iCLK = ~iCLK;

    // Clock edges since the last reset edge; the tone phase is a pure function of it.
    always @(posedge iCLK) begin
        if (iRST) edge_count = 0;
        else      edge_count++;
    end

    function automatic string morse_of(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
        if (u >= 8'h41 && u <= 8'h5A) return letter_code[int'(u) - 65];
        if (u >= 8'h30 && u <= 8'h39) return digit_code[int'(u) - 48];
        if (u == 8'h20) return " ";
        return "";
    endfunction

    function automatic bit tone_phase();
        return (edge_count >= 1) && ((((edge_count - 1) / TONE) % 2) == 1);
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_cycle(input string tag, input bit key, input bit ready, input bit err);
        checkOutput({tag, " oKEY"}, oKEY, key);
        checkOutput({tag, " oREADY"}, oREADY, ready);
        checkOutput({tag, " oBUSY"}, oBUSY, !ready);
        checkOutput({tag, " oERR"}, oERR, err);
        checkOutput({tag, " oSOUND"}, oSOUND, key & tone_phase());
    endtask

    // Hands one character over in the current idle cycle and follows it to the next idle cycle.
    task automatic applyStimulus(input logic [7:0] ch, input string code, input bit hold);
        bit    keyq[$];
        string tag;
        tag  = $sformatf("chr%02h", ch);
        keyq = {};
        if (code == " ") begin
            repeat (4 * UNIT) keyq.push_back(1'b0);
        end else begin
            for (int i = 0; i < code.len(); i++) begin
                repeat ((code[i] == 8'h2D ? 3 : 1) * UNIT) keyq.push_back(1'b1);
                repeat ((i == code.len() - 1 ? 3 : 1) * UNIT) keyq.push_back(1'b0);
            end
        end
        iCHAR  = ch;
        iVALID = 1'b1;
        @(posedge iCLK);
        #1;
        if (!hold) iVALID = 1'b0;
        @(negedge iCLK);
        check_cycle(tag, 1'b0, 1'b0, 1'b0);
        foreach (keyq[i]) begin
            @(negedge iCLK);
            check_cycle(tag, keyq[i], 1'b0, 1'b0);
        end
        @(negedge iCLK);
        check_cycle(tag, 1'b0, 1'b1, code.len() == 0);
    endtask

    task automatic add_vec(input logic [7:0] ch, input string code, input bit hold);
        vec_t v;
        v.ch   = ch;
        v.code = code;
        v.hold = hold;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] rc;
        bit         rh;
        bit         exp_key;

        add_vec(8'h45, ".", 1'b0);
        add_vec(8'h61, ".-", 1'b0);
        add_vec(8'h45, ".", 1'b1);
        add_vec(8'h20, " ", 1'b1);
        add_vec(8'h45, ".", 1'b0);
        add_vec(8'h23, "", 1'b0);
        add_vec(8'h51, "--.-", 1'b0);
        add_vec(8'h35, ".....", 1'b1);
        add_vec(8'h7A, "--..", 1'b1);
        add_vec(8'h39, "----.", 1'b0);
        add_vec(8'h6D, "--", 1'b0);

        // Reset held with a pending request: nothing may be accepted or keyed.
        iRST   = 1'b1;
        iVALID = 1'b1;
        iCHAR  = 8'h45;
        repeat (3) begin
            @(negedge iCLK);
            checkOutput("reset oKEY", oKEY, 1'b0);
            checkOutput("reset oSOUND", oSOUND, 1'b0);
            checkOutput("reset oBUSY", oBUSY, 1'b0);
            checkOutput("reset oERR", oERR, 1'b0);
        end
        iRST   = 1'b0;
        iVALID = 1'b0;
        repeat (2) begin
            @(negedge iCLK);
            checkOutput("post-reset oREADY", oREADY, 1'b1);
            checkOutput("post-reset oBUSY", oBUSY, 1'b0);
        end

        foreach (vecs[i]) applyStimulus(vecs[i].ch, vecs[i].code, vecs[i].hold);

        // Unsupported character: the error pulse lasts exactly one cycle.
        applyStimulus(8'h23, "", 1'b0);
        @(negedge iCLK);
        checkOutput("err pulse end oERR", oERR, 1'b0);
        checkOutput("err pulse end oREADY", oREADY, 1'b1);

        // '0' aborted by reset during its second dash, then a clean 'T'.
        iCHAR  = 8'h30;
        iVALID = 1'b1;
        @(posedge iCLK);
        #1;
        iVALID = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge iCLK);
            exp_key = (k >= 2 && k <= 13) || (k >= 18);
            check_cycle($sformatf("abort T+%0d", k), exp_key, 1'b0, 1'b0);
        end
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        @(negedge iCLK);
        check_cycle("after abort", 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h54, "-", 1'b0);

        // Random characters including lower case, spaces and unsupported codes.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: rc = 8'h41 + 8'($urandom_range(0, 25));
                1: rc = 8'h61 + 8'($urandom_range(0, 25));
                2: rc = 8'h30 + 8'($urandom_range(0, 9));
                3: rc = 8'h20;
                default: begin
                    do rc = 8'($urandom_range(0, 255));
                    while (morse_of(rc).len() != 0);
                end
            endcase
            rh = 1'($urandom_range(0, 1));
            applyStimulus(rc, morse_of(rc), rh);
        end
        iVALID = 1'b0;
        @(negedge iCLK);
        checkOutput("final oBUSY", oBUSY, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
